// File: rtl/spi_target.sv
// CPHA=0 SPI target that turns write/read frames into a byte-wide register port.
// Defining SPI_TARGET_STATUS_EN adds command 0x05, which reads back the count of completed writes.
module spi_target #(
  parameter int SYNC_STAGE   = 2,
  parameter bit CPOL         = 1'b1,
  parameter int DUMMY_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ssel,
  output logic       miso,
  output logic       miso_oe,
  output logic       write_enable,
  output logic [7:0] write_address,
  output logic [7:0] write_data,
  output logic [7:0] read_address,
  input  logic [7:0] read_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_WDATA, ST_RDATA, ST_IGNORE
  } state_t;

  localparam logic [2:0] FLUSH_LAST = 3'(SYNC_STAGE + 1);
  localparam logic [2:0] DUMMY_LAST = 3'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

  state_t                state_q, state_d;
  logic [SYNC_STAGE-1:0] sclk_sync_q, mosi_sync_q, ssel_sync_q;
  logic                  sclk_prev_q, ssel_prev_q;
  logic                  armed_q, armed_d;
  logic [2:0]            flush_cnt_q, flush_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_in_q, shift_in_d;
  logic [7:0]            shift_out_q, shift_out_d;
  logic [7:0]            addr_q, addr_d;
  logic                  is_write_q, is_write_d;
  logic                  shift_ok_q, shift_ok_d;
  logic                  load1_q, load1_d, load2_q, load2_d;
  logic                  miso_q, miso_d, miso_oe_q, miso_oe_d, busy_q, busy_d;
  logic                  write_enable_q, write_enable_d;
  logic [7:0]            write_address_q, write_address_d;
  logic [7:0]            write_data_q, write_data_d;
  logic [7:0]            read_address_q, read_address_d;
`ifdef SPI_TARGET_STATUS_EN
  logic                  is_status_q, is_status_d;
  logic [7:0]            wr_count_q, wr_count_d;
`endif

  logic       sclk_s, mosi_s, ssel_s, lead_s, trail_s, ssel_fall_s, last_bit_s;
  logic [7:0] byte_s;

  assign sclk_s      = sclk_sync_q[SYNC_STAGE-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGE-1];
  assign ssel_s      = ssel_sync_q[SYNC_STAGE-1];
  assign lead_s      = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
  assign trail_s     = (sclk_prev_q != CPOL) && (sclk_s == CPOL);
  assign ssel_fall_s = ssel_prev_q && !ssel_s;
  assign byte_s      = {shift_in_q[6:0], mosi_s};
  assign last_bit_s  = lead_s && (bit_cnt_q == 3'd7);

  // A frame is only accepted after ssel has been seen high with flushed synchronizers,
  // so a frame already in progress at reset release is never joined mid-way.
  always_comb begin
    state_d         = state_q;
    armed_d         = armed_q;
    flush_cnt_d     = flush_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_in_d      = shift_in_q;
    shift_out_d     = shift_out_q;
    addr_d          = addr_q;
    is_write_d      = is_write_q;
    shift_ok_d      = shift_ok_q;
    load1_d         = 1'b0;
    load2_d         = load1_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    read_address_d  = read_address_q;
`ifdef SPI_TARGET_STATUS_EN
    is_status_d     = is_status_q;
    wr_count_d      = wr_count_q;
`endif

    if (armed_q) begin
      armed_d = 1'b1;
    end else if (flush_cnt_q != FLUSH_LAST) begin
      flush_cnt_d = flush_cnt_q + 3'd1;
    end else begin
      armed_d = ssel_s && ssel_prev_q;
    end

    if ((state_q != ST_IDLE) && ssel_s) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      shift_ok_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d   = 3'd0;
          shift_ok_d  = 1'b0;
          shift_out_d = 8'd0;
          if (ssel_fall_s && armed_q) state_d = ST_CMD;
          else                        state_d = ST_IDLE;
        end
        ST_CMD: begin
          if (lead_s) begin
            shift_in_d = byte_s;
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end else begin
            shift_in_d = shift_in_q;
          end
          if (last_bit_s) begin
            is_write_d = (byte_s == 8'h02);
`ifdef SPI_TARGET_STATUS_EN
            is_status_d = 1'b0;
            if (byte_s == 8'h05) begin
              is_status_d = 1'b1;
              state_d     = ST_RDATA;
              shift_ok_d  = 1'b0;
              load1_d     = 1'b1;
            end else
`endif
            if ((byte_s == 8'h02) || (byte_s == 8'h03)) state_d = ST_ADDR;
            else                                         state_d = ST_IGNORE;
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (lead_s) begin
            shift_in_d = byte_s;
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end else begin
            shift_in_d = shift_in_q;
          end
          if (last_bit_s) begin
            addr_d = byte_s;
            if (is_write_q) begin
              state_d = ST_WDATA;
            end else if (DUMMY_CYCLES > 0) begin
              state_d = ST_DUMMY;
            end else begin
              state_d        = ST_RDATA;
              read_address_d = byte_s;
              addr_d         = byte_s + 8'd1;
              shift_ok_d     = 1'b0;
              load1_d        = 1'b1;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_DUMMY: begin
          if (lead_s && (bit_cnt_q == DUMMY_LAST)) begin
            bit_cnt_d      = 3'd0;
            state_d        = ST_RDATA;
            read_address_d = addr_q;
            addr_d         = addr_q + 8'd1;
            shift_ok_d     = 1'b0;
            load1_d        = 1'b1;
          end else if (lead_s) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        ST_WDATA: begin
          if (lead_s) begin
            shift_in_d = byte_s;
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end else begin
            shift_in_d = shift_in_q;
          end
          if (last_bit_s) begin
            write_enable_d  = 1'b1;
            write_data_d    = byte_s;
            write_address_d = addr_q;
            addr_d          = addr_q + 8'd1;
          end else begin
            write_enable_d  = 1'b0;
          end
        end
        ST_RDATA: begin
          // The trailing edge right after a byte's 8th bit must not shift: the next byte is loading.
          if (last_bit_s) begin
            bit_cnt_d  = 3'd0;
            shift_ok_d = 1'b0;
            load1_d    = 1'b1;
`ifdef SPI_TARGET_STATUS_EN
            if (!is_status_q) begin
              read_address_d = addr_q;
              addr_d         = addr_q + 8'd1;
            end else begin
              read_address_d = read_address_q;
            end
`else
            read_address_d = addr_q;
            addr_d         = addr_q + 8'd1;
`endif
          end else if (lead_s) begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            shift_ok_d = 1'b1;
          end else if (trail_s && shift_ok_q) begin
            shift_out_d = {shift_out_q[6:0], 1'b0};
          end else begin
            shift_out_d = shift_out_q;
          end
        end
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end

    if (load2_q) begin
`ifdef SPI_TARGET_STATUS_EN
      shift_out_d = is_status_q ? wr_count_q : read_data;
`else
      shift_out_d = read_data;
`endif
    end else begin
      shift_out_d = shift_out_d;
    end

`ifdef SPI_TARGET_STATUS_EN
    if (write_enable_d) wr_count_d = wr_count_q + 8'd1;
    else                wr_count_d = wr_count_q;
`endif

    miso_oe_d = (state_d == ST_RDATA);
    miso_d    = miso_oe_d & shift_out_d[7];
    busy_d    = (state_d != ST_IDLE);
  end

  // All state, synchronizers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      sclk_sync_q     <= {SYNC_STAGE{CPOL}};
      mosi_sync_q     <= {SYNC_STAGE{1'b0}};
      ssel_sync_q     <= {SYNC_STAGE{1'b1}};
      sclk_prev_q     <= CPOL;
      ssel_prev_q     <= 1'b1;
      armed_q         <= 1'b0;
      flush_cnt_q     <= 3'd0;
      bit_cnt_q       <= 3'd0;
      shift_in_q      <= 8'd0;
      shift_out_q     <= 8'd0;
      addr_q          <= 8'd0;
      is_write_q      <= 1'b0;
      shift_ok_q      <= 1'b0;
      load1_q         <= 1'b0;
      load2_q         <= 1'b0;
      miso_q          <= 1'b0;
      miso_oe_q       <= 1'b0;
      busy_q          <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= 8'd0;
      write_data_q    <= 8'd0;
      read_address_q  <= 8'd0;
`ifdef SPI_TARGET_STATUS_EN
      is_status_q     <= 1'b0;
      wr_count_q      <= 8'd0;
`endif
    end else begin
      state_q         <= state_d;
      sclk_sync_q     <= {sclk_sync_q[SYNC_STAGE-2:0], sclk};
      mosi_sync_q     <= {mosi_sync_q[SYNC_STAGE-2:0], mosi};
      ssel_sync_q     <= {ssel_sync_q[SYNC_STAGE-2:0], ssel};
      sclk_prev_q     <= sclk_s;
      ssel_prev_q     <= ssel_s;
      armed_q         <= armed_d;
      flush_cnt_q     <= flush_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_in_q      <= shift_in_d;
      shift_out_q     <= shift_out_d;
      addr_q          <= addr_d;
      is_write_q      <= is_write_d;
      shift_ok_q      <= shift_ok_d;
      load1_q         <= load1_d;
      load2_q         <= load2_d;
      miso_q          <= miso_d;
      miso_oe_q       <= miso_oe_d;
      busy_q          <= busy_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      read_address_q  <= read_address_d;
`ifdef SPI_TARGET_STATUS_EN
      is_status_q     <= is_status_d;
      wr_count_q      <= wr_count_d;
`endif
    end
  end

  assign miso          = miso_q;
  assign miso_oe       = miso_oe_q;
  assign busy          = busy_q;
  assign write_enable  = write_enable_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign read_address  = read_address_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: directed vector table, hand-built abort/reset sequences and random frames
// checked against an address/data reference model.
module tb_spi_target;
  localparam int SYNC_STAGE = 2;
  localparam bit CPOL       = 1'b1;
  localparam int HALF       = 8;

  logic       clk = 1'b0;
  logic       reset, sclk, mosi, ssel;
  logic       miso, miso_oe, write_enable, busy;
  logic [7:0] write_address, write_data, read_address, read_data;

  always #5 clk = ~clk;

  spi_target #(.SYNC_STAGE(SYNC_STAGE), .CPOL(CPOL), .DUMMY_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ssel(ssel),
    .miso(miso), .miso_oe(miso_oe), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data),
    .read_address(read_address), .read_data(read_data), .busy(busy)
  );

  logic [7:0] mem [256];
  always @(posedge clk) read_data <= mem[read_address];

  logic [7:0] wl_a [1024];
  logic [7:0] wl_d [1024];
  int         wr_n = 0, oe_seen = 0, miso_viol = 0, ra_chg = 0;
  logic [7:0] ra_last;

  always @(negedge clk) begin
    if (write_enable && (wr_n < 1024)) begin
      wl_a[wr_n] <= write_address;
      wl_d[wr_n] <= write_data;
      wr_n       <= wr_n + 1;
    end
    if (miso_oe) oe_seen <= oe_seen + 1;
    if (!miso_oe && miso) miso_viol <= miso_viol + 1;
    if (read_address !== ra_last) ra_chg <= ra_chg + 1;
    ra_last <= read_address;
  end

  int         checks = 0, errors = 0;
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];
  int         oe_hi;
  logic       busy_before, busy_after;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    check("reset_outputs", {miso, miso_oe, write_enable, write_address, write_data, read_address, busy}, 32'd0);
    reset = 1'b0;
    tick(SYNC_STAGE + 6);
  endtask

  task automatic spi_start();
    ssel = 1'b0;
    tick(HALF);
  endtask

  task automatic spi_bit(input logic b, output logic r, output logic oe);
    mosi = b;
    tick(HALF);
    r    = miso;
    oe   = miso_oe;
    sclk = ~CPOL;
    tick(HALF);
    sclk = CPOL;
  endtask

  task automatic spi_stop();
    tick(HALF);
    busy_before = busy;
    ssel = 1'b1;
    mosi = 1'b0;
    tick(SYNC_STAGE + 1);
    busy_after = busy;
    tick(2 * HALF);
  endtask

  task automatic spi_bits(input int first, input int nbits);
    logic r, oe;
    for (int i = first; i < first + nbits; i++) begin
      spi_bit(tx_buf[i / 8][7 - (i % 8)], r, oe);
      rx_buf[i / 8][7 - (i % 8)] = r;
      if (oe) oe_hi++;
    end
  endtask

  task automatic spi_frame(input int nbits);
    oe_hi = 0;
    spi_start();
    spi_bits(0, nbits);
    spi_stop();
  endtask

  typedef struct {
    string      name;
    logic [7:0] cmd, addr;
    int         nbytes;
    logic [7:0] d0, d1;
    int         exp_wr;
    logic [7:0] ea0, ed0, ea1, ed1;
    int         exp_oe;
  } vec_t;

  function automatic vec_t mkv(string n, logic [7:0] c, logic [7:0] a, int nb, logic [7:0] d0,
                               logic [7:0] d1, int ew, logic [7:0] ea0, logic [7:0] ed0,
                               logic [7:0] ea1, logic [7:0] ed1, int eoe);
    vec_t v;
    v.name = n; v.cmd = c; v.addr = a; v.nbytes = nb; v.d0 = d0; v.d1 = d1; v.exp_wr = ew;
    v.ea0 = ea0; v.ed0 = ed0; v.ea1 = ea1; v.ed1 = ed1; v.exp_oe = eoe;
    return v;
  endfunction

  vec_t vecs [7];

  initial begin
    int         base, oe0, chg0, nb, trunc, nbits, exp_wr;
    logic       is_rd, r, oe;
    logic [7:0] a;

    vecs[0] = mkv("wr_two",  8'h02, 8'h10, 2, 8'hA5, 8'h5A, 2, 8'h10, 8'hA5, 8'h11, 8'h5A, 0);
    vecs[1] = mkv("wr_wrap", 8'h02, 8'hFF, 2, 8'h12, 8'h34, 2, 8'hFF, 8'h12, 8'h00, 8'h34, 0);
    vecs[2] = mkv("rd_20",   8'h03, 8'h20, 1, 8'h00, 8'h00, 0, 8'h00, 8'h3C, 8'h00, 8'h00, 8);
    vecs[3] = mkv("rd_wrap", 8'h03, 8'hFF, 2, 8'h00, 8'h00, 0, 8'h00, 8'h5A, 8'h00, 8'hA5, 16);
    vecs[4] = mkv("ign_9f",  8'h9F, 8'h5A, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    vecs[5] = mkv("wr_one",  8'h02, 8'h7E, 1, 8'hC3, 8'h00, 1, 8'h7E, 8'hC3, 8'h00, 8'h00, 0);
    vecs[6] = mkv("rd_21",   8'h03, 8'h21, 2, 8'h00, 8'h00, 0, 8'h00, 8'h84, 8'h00, 8'h87, 16);

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h20] = 8'h3C;
    sclk = CPOL; ssel = 1'b1; mosi = 1'b0;
    do_reset();
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      tx_buf[0] = vecs[v].cmd; tx_buf[1] = vecs[v].addr;
      tx_buf[2] = vecs[v].d0;  tx_buf[3] = vecs[v].d1;
      base = wr_n; oe0 = oe_seen;
      spi_frame(16 + 8 * vecs[v].nbytes);
      check($sformatf("%s_wr_count", vecs[v].name), wr_n - base, vecs[v].exp_wr);
      if (vecs[v].exp_wr >= 1) begin
        check($sformatf("%s_wa0", vecs[v].name), wl_a[base], vecs[v].ea0);
        check($sformatf("%s_wd0", vecs[v].name), wl_d[base], vecs[v].ed0);
      end
      if (vecs[v].exp_wr >= 2) begin
        check($sformatf("%s_wa1", vecs[v].name), wl_a[base + 1], vecs[v].ea1);
        check($sformatf("%s_wd1", vecs[v].name), wl_d[base + 1], vecs[v].ed1);
      end
      if (vecs[v].cmd == 8'h03) begin
        check($sformatf("%s_rd0", vecs[v].name), rx_buf[2], vecs[v].ed0);
        if (vecs[v].nbytes >= 2) check($sformatf("%s_rd1", vecs[v].name), rx_buf[3], vecs[v].ed1);
      end else begin
        check($sformatf("%s_oe_cycles", vecs[v].name), oe_seen - oe0, 0);
      end
      check($sformatf("%s_oe_bits", vecs[v].name), oe_hi, vecs[v].exp_oe);
      check($sformatf("%s_busy_in", vecs[v].name), {31'd0, busy_before}, 32'd1);
      check($sformatf("%s_busy_out", vecs[v].name), {31'd0, busy_after}, 32'd0);
    end

    // ssel raised after 5 bits of the first data byte
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h40; tx_buf[2] = 8'hE7;
    base = wr_n;
    spi_frame(21);
    check("abort5_writes", wr_n - base, 0);
    check("abort5_busy_in", {31'd0, busy_before}, 32'd1);
    check("abort5_busy_out", {31'd0, busy_after}, 32'd0);

    // ssel deasserts on the same edge that completes the 8th data bit
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h41; tx_buf[2] = 8'h81;
    base = wr_n; oe_hi = 0;
    spi_start();
    spi_bits(0, 23);
    mosi = 1'b1;
    tick(HALF);
    sclk = ~CPOL; ssel = 1'b1;
    tick(HALF);
    sclk = CPOL;
    tick(SYNC_STAGE + 1);
    check("simul_busy", {31'd0, busy}, 32'd0);
    mosi = 1'b0;
    tick(2 * HALF);
    check("simul_writes", wr_n - base, 0);

    // reset in the middle of a frame: the rest of that frame must be ignored
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h50; tx_buf[2] = 8'h99;
    base = wr_n; oe_hi = 0;
    spi_start();
    spi_bits(0, 12);
    do_reset();
    spi_bits(12, 12);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    spi_stop();
    check("rst_mid_writes", wr_n - base, 0);
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h30; tx_buf[2] = 8'h66;
    spi_frame(24);
    check("rst_after_count", wr_n - base, 1);
    check("rst_after_wa", wl_a[base], 8'h30);
    check("rst_after_wd", wl_d[base], 8'h66);

    // random frames against the model
    for (int t = 0; t < 16; t++) begin
      is_rd = 1'($urandom_range(0, 1));
      tx_buf[0] = is_rd ? 8'h03 : 8'h02;
      tx_buf[1] = 8'($urandom);
      nb = $urandom_range(1, 3);
      for (int k = 0; k < 3; k++) tx_buf[2 + k] = 8'($urandom);
      trunc = (!is_rd && ($urandom_range(0, 3) == 0)) ? $urandom_range(1, 7) : 0;
      nbits = 16 + 8 * nb - trunc;
      exp_wr = is_rd ? 0 : (nbits - 16) / 8;
      base = wr_n;
      spi_frame(nbits);
      check($sformatf("rnd%0d_wr_count", t), wr_n - base, exp_wr);
      for (int k = 0; k < exp_wr; k++) begin
        a = tx_buf[1] + 8'(k);
        check($sformatf("rnd%0d_wa%0d", t, k), wl_a[base + k], a);
        check($sformatf("rnd%0d_wd%0d", t, k), wl_d[base + k], tx_buf[2 + k]);
      end
      if (is_rd) begin
        for (int k = 0; k < nb; k++) begin
          a = tx_buf[1] + 8'(k);
          check($sformatf("rnd%0d_rd%0d", t, k), rx_buf[2 + k], mem[a]);
        end
      end
      check($sformatf("rnd%0d_oe_bits", t), oe_hi, is_rd ? 8 * nb : 0);
    end

`ifdef SPI_TARGET_STATUS_EN
    do_reset();
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h50;
    tx_buf[2] = 8'h11; tx_buf[3] = 8'h22; tx_buf[4] = 8'h33;
    base = wr_n;
    spi_frame(40);
    check("status_pre_writes", wr_n - base, 3);
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    chg0 = ra_chg;
    spi_frame(24);
    check("status_byte0", rx_buf[1], 8'h03);
    check("status_byte1", rx_buf[2], 8'h03);
    check("status_oe_bits", oe_hi, 16);
    check("status_ra_stable", ra_chg - chg0, 0);
`else
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h20; tx_buf[2] = 8'h77;
    base = wr_n; oe0 = oe_seen; chg0 = ra_chg;
    spi_frame(24);
    check("cmd05_writes", wr_n - base, 0);
    check("cmd05_oe_cycles", oe_seen - oe0, 0);
    check("cmd05_busy_in", {31'd0, busy_before}, 32'd1);
`endif

    check("miso_low_when_no_oe", miso_viol, 0);
    r = 1'b0; oe = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter SYNC_STAGE, default 2: synchronizer depth for sclk, mosi and ssel, legal range 2..4.
REQ-002 SHALL have parameter CPOL, default 1: sclk idle level; the leading edge is the first edge away from CPOL.
REQ-003 SHALL have parameter DUMMY_CYCLES, default 0: number of sclk cycles between address and read data, legal range 0..7.
REQ-004 SHALL have ports: clk input 1 (single clock); reset input 1 (synchronous, active-high).
REQ-005 SHALL have ports: sclk input 1; mosi input 1; ssel input 1 (active-low); miso output 1; miso_oe output 1.
REQ-006 SHALL have ports: write_enable output 1; write_address output 8; write_data output 8.
REQ-007 SHALL have ports: read_address output 8; read_data input 8 (valid 1 clk after read_address); busy output 1.

Function
REQ-008 SHALL pass sclk, mosi and ssel through SYNC_STAGE flops on clk, then detect leading and trailing edges with one extra flop stage.
REQ-009 SHALL operate in CPHA=0: sample mosi on the leading edge, MSB first; update miso on the trailing edge.
REQ-010 SHALL support a legal sclk frequency of at most clk/(2*(SYNC_STAGE+3)); behaviour above this rate is undefined.
REQ-011 SHALL implement the FSM states IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, IGNORE.
REQ-012 SHALL move IDLE->CMD on a synchronized ssel falling edge and clear the bit counter.
REQ-013 SHALL, after 8 CMD bits, decode the command: 0x02 (write) -> ADDR; 0x03 (read) -> ADDR; any other value -> IGNORE.
REQ-014 SHALL, after 8 ADDR bits, latch the address, then go to WDATA on a write, DUMMY on a read with DUMMY_CYCLES>0, or RDATA otherwise.
REQ-015 SHALL leave DUMMY after DUMMY_CYCLES leading edges, with mosi ignored while in DUMMY.
REQ-016 SHALL, in WDATA, pulse write_enable for exactly 1 clk after each 8th sampled bit, with write_data = the assembled byte and write_address = the current address; the address then increments modulo 256 (0xFF wraps to 0x00).
REQ-017 SHALL, in RDATA, drive read_address = the current address one clk after state entry and after each 8th leading edge; the shift register loads read_data 1 clk later and the address increments modulo 256.
REQ-018 SHALL present the first data bit (MSB) on miso before the first RDATA leading edge and shift on each subsequent trailing edge.
REQ-019 SHALL hold miso_oe=1 only in RDATA, and 0 otherwise; miso SHALL be 0 whenever miso_oe=0.
REQ-020 SHALL, in IGNORE, produce no writes and hold miso_oe=0 until ssel deasserts.
REQ-021 SHALL, on ssel rising edge in any state, return to IDLE within 1 clk, discard any partial byte, and issue no write_enable for it.
REQ-022 SHALL, when ssel deasserts and the 8th bit completes in the same clk, give deassertion priority: no write occurs.
REQ-023 SHALL hold busy=1 in every state except IDLE.

Reset
REQ-024 SHALL, while reset=1 on a clk edge, set state=IDLE, clear counters, address and shift registers, and load the synchronizers with idle values (sclk=CPOL, ssel=1, mosi=0).
REQ-025 SHALL hold all outputs at 0 in reset: miso, miso_oe, write_enable, write_address, write_data, read_address, busy.
REQ-026 SHALL, on reset mid-transfer, abort the transaction; after release it SHALL wait for a fresh ssel falling edge and not resynchronize to the frame in progress.

Configuration
REQ-027 SHALL, with SPI_TARGET_STATUS_EN defined, accept command 0x05: skip ADDR/DUMMY, enter RDATA, and return an 8-bit count of completed write bytes (modulo 256, cleared by reset) repeatedly until ssel deasserts; read_address SHALL NOT change.
REQ-028 SHALL, without SPI_TARGET_STATUS_EN, treat 0x05 as an unknown command (IGNORE) and omit the counter logic.

Verification
REQ-029 SHALL cover: write 0x02,0x10,0xA5,0x5A -> write_enable pulses twice, (0x10,0xA5) then (0x11,0x5A).
REQ-030 SHALL cover: memory[0x20]=0x3C, DUMMY_CYCLES=0, read 0x03,0x20 plus 8 clocks -> miso shifts out 0x3C MSB first with miso_oe=1.
REQ-031 SHALL cover: write at address 0xFF with 2 data bytes -> writes land at 0xFF then 0x00.
REQ-032 SHALL cover: ssel raised after 5 bits of a data byte -> no write_enable, busy=0 and state IDLE within 1 clk.
REQ-033 SHALL cover: command 0x9F followed by 16 clocks -> no writes, miso_oe=0 throughout.
REQ-034 SHALL cover, with SPI_TARGET_STATUS_EN defined: 3 bytes written, then command 0x05 -> miso returns 0x03.
